// File: rtl/rc_pkg.sv
// Shared types and constants for the batched rcPermutation driver and core.
package rc_pkg;
  localparam int N_BITS     = 254;
  localparam int STATE_SIZE = 3;
  localparam int LANES      = 13;
  localparam int RATE       = 2;
  localparam int LANE_IW    = $clog2(LANES + 1);

  typedef logic [N_BITS-1:0] fe_t;
  typedef fe_t [STATE_SIZE-1:0] lane_state_t;
  typedef lane_state_t [LANES-1:0] batch_t;

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} drv_state_e;

  localparam fe_t PRIME_MODULUS =
    254'd21888242871839275222246405745257275088548364400416034343698204186575808495617;
  // floor(2^(2*N_BITS) / p), the Barrett factor the core reduces with
  localparam logic [511:0] BARRETT_WIDE =
    (512'd1 << (2 * N_BITS)) / {258'd0, PRIME_MODULUS};
  localparam logic [N_BITS:0] BARRETT_R = BARRETT_WIDE[N_BITS:0];
endpackage

// File: rtl/rc_batch_driver_buf.sv
// LANES x STATE_SIZE register file: single-lane write, whole-batch capture,
// indexed lane read and synchronous clear.
module rc_lane_buffer
  import rc_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       i_wr_en,
  input  logic [LANE_IW-1:0]                         i_wr_idx,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]          i_wr_data,
  input  logic                                       i_cap_en,
  input  logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] i_cap_data,
  input  logic                                       i_clr,
  input  logic [LANE_IW-1:0]                         i_rd_idx,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]          o_rd_data,
  output logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] o_all
);
  batch_t r_mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= '0;
    end else if (i_clr) begin
      r_mem <= '0;
    end else if (i_cap_en) begin
      r_mem <= i_cap_data;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_all     = r_mem;
endmodule

// File: rtl/rc_batch_driver.sv
// Packs rate-sized absorb beats into one rcPermutation batch, runs the core,
// and streams the permuted lane states back out in lane order.
module rc_batch_driver
  import rc_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [RATE*N_BITS-1:0]                       in_data,
  input  logic                                         in_last,
  output logic                                         perm_enable,
  output logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] perm_inState,
  input  logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] perm_outState,
  input  logic                                         perm_done,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [STATE_SIZE*N_BITS-1:0]                 out_data,
  output logic                                         out_last
);
  drv_state_e          r_state;
  logic [LANE_IW-1:0]  r_count;
  logic [LANE_IW-1:0]  r_rd;
  logic                r_in_ready;
  logic                r_perm_enable;
  logic                r_out_valid;
  logic                r_out_last;

  logic                w_accept;
  logic                w_capture;
  logic                w_finish;
  lane_state_t         w_wr_state;
  lane_state_t         w_unused_in_rd;
  batch_t              w_unused_res_all;

  assign w_accept   = (r_state == FILL) && r_in_ready && in_valid;
  assign w_capture  = (r_state == WAIT) && perm_done;
  assign w_finish   = (r_state == DRAIN) && out_ready && (r_rd == r_count - LANE_IW'(1));
  // capacity elements of an absorb block start at zero
  assign w_wr_state = lane_state_t'({{((STATE_SIZE - RATE) * N_BITS){1'b0}}, in_data});

  rc_lane_buffer u_in_buf (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_accept),
    .i_wr_idx   (r_count),
    .i_wr_data  (w_wr_state),
    .i_cap_en   (1'b0),
    .i_cap_data ('0),
    .i_clr      (w_finish),
    .i_rd_idx   (LANE_IW'(0)),
    .o_rd_data  (w_unused_in_rd),
    .o_all      (perm_inState)
  );

  rc_lane_buffer u_res_buf (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (1'b0),
    .i_wr_idx   (LANE_IW'(0)),
    .i_wr_data  ('0),
    .i_cap_en   (w_capture),
    .i_cap_data (perm_outState),
    .i_clr      (1'b0),
    .i_rd_idx   (r_rd),
    .o_rd_data  (out_data),
    .o_all      (w_unused_res_all)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= FILL;
      r_count       <= '0;
      r_rd          <= '0;
      r_in_ready    <= 1'b0;
      r_perm_enable <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else if (in_valid) begin
            r_count <= r_count + LANE_IW'(1);
            if (in_last || (r_count == LANE_IW'(LANES - 1))) begin
              r_in_ready <= 1'b0;
              r_state    <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          // a done still high from the previous batch must clear first
          if (!perm_done) begin
            r_perm_enable <= 1'b1;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (perm_done) begin
            r_perm_enable <= 1'b0;
            r_out_valid   <= 1'b1;
            r_out_last    <= (r_count == LANE_IW'(1));
            r_rd          <= '0;
            r_state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (w_finish) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_count     <= '0;
              r_rd        <= '0;
              r_in_ready  <= 1'b1;
              r_state     <= FILL;
            end else begin
              r_rd       <= r_rd + LANE_IW'(1);
              r_out_last <= ((r_rd + LANE_IW'(2)) == r_count);
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign perm_enable = r_perm_enable;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
endmodule

// File: tb/tb_rc_batch_driver.sv
// Directed bench for rc_batch_driver with a behavioural permutation core.
module tb_rc_batch_driver;
  import rc_pkg::*;

  logic                                         clk;
  logic                                         reset;
  logic                                         in_valid;
  logic                                         in_ready;
  logic [RATE*N_BITS-1:0]                       in_data;
  logic                                         in_last;
  logic                                         perm_enable;
  logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] perm_inState;
  logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] perm_outState;
  logic                                         perm_done;
  logic                                         out_valid;
  logic                                         out_ready;
  logic [STATE_SIZE*N_BITS-1:0]                 out_data;
  logic                                         out_last;

  int n_chk  = 0;
  int n_fail = 0;
  int core_lat   = 2;
  int extra_hold = 0;
  lane_state_t exp_q [LANES];

  localparam fe_t R0 = 254'd12360106593270449844061412657301362366573579256583003766552363058581964117186;
  localparam fe_t R1 = 254'd571281065699991603834232145226702411332243584689159097661681181035646779147;
  localparam fe_t R2 = 254'd5827211446942541137487801220137246525465448099690109106563675347241842025991;

  rc_batch_driver dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .perm_enable   (perm_enable),
    .perm_inState  (perm_inState),
    .perm_outState (perm_outState),
    .perm_done     (perm_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for rcPermutation: known answer for [7,5,0], lane-tagged transform otherwise.
  function automatic lane_state_t core_f(input lane_state_t s, input int lane);
    lane_state_t r;
    if (s == {fe_t'(0), fe_t'(5), fe_t'(7)}) begin
      r = {R2, R1, R0};
    end else begin
      for (int j = 0; j < STATE_SIZE; j++) r[j] = ~s[j] + fe_t'(lane * 8 + j + 1);
    end
    return r;
  endfunction

  function automatic lane_state_t mk(input fe_t a, input fe_t b);
    return {fe_t'(0), b, a};
  endfunction

  initial begin : core_model
    int cnt;
    int hold;
    cnt = 0;
    hold = 0;
    perm_done = 1'b0;
    perm_outState = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        perm_done = 1'b0;
        cnt = 0;
      end else if (!perm_done) begin
        if (perm_enable) begin
          cnt++;
          if (cnt >= core_lat) begin
            for (int l = 0; l < LANES; l++) perm_outState[l] = core_f(perm_inState[l], l);
            perm_done = 1'b1;
            hold = extra_hold;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else if (!perm_enable) begin
        if (hold > 0) hold--;
        else perm_done = 1'b0;
      end
    end
  end

  task automatic send_beat(input fe_t e0, input fe_t e1, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = {e1, e0};
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("beat_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1; mode 2: ready, in_ready must stay low
  task automatic collect(input int n, input int mode);
    int k;
    int cyc;
    logic held;
    lane_state_t hold_d;
    k = 0;
    cyc = 0;
    held = 1'b0;
    hold_d = '0;
    while (k < n && cyc < 400) begin
      out_ready = (mode != 1) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (held) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, hold_d);
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("data_lane%0d", k), out_data, exp_q[k]);
          chk($sformatf("last_lane%0d", k), out_last, (k == n - 1));
          k++;
        end else begin
          held = 1'b1;
          hold_d = out_data;
        end
      end
      if (mode == 2) chk("busy_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      cyc++;
    end
    if (k < n) chk("drain_timeout", k, n);
    chk("no_extra_beat", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int waited;
    logic seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_enable", perm_enable, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_inState", |perm_inState, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // single [7,5] beat closed by in_last
    send_beat(fe_t'(7), fe_t'(5), 1'b1);
    chk("t1_lane0_in", perm_inState[0], mk(fe_t'(7), fe_t'(5)));
    chk("t1_lane1_in", perm_inState[1], '0);
    chk("t1_in_ready", in_ready, 1'b0);
    exp_q[0] = {R2, R1, R0};
    collect(1, 0);

    // full batch auto-launches on the 13th beat
    for (int i = 0; i < LANES; i++) begin
      send_beat(fe_t'(1000 + i * 3), fe_t'(2000 + i * 7), 1'b0);
      exp_q[i] = core_f(mk(fe_t'(1000 + i * 3), fe_t'(2000 + i * 7)), i);
    end
    chk("t2_in_ready", in_ready, 1'b0);
    chk("t2_lane12_in", perm_inState[12], mk(fe_t'(1036), fe_t'(2084)));
    chk("t2_en_lat0", perm_enable, 1'b0);
    @(posedge clk); #1;
    chk("t2_en_lat1", perm_enable, 1'b1);
    collect(LANES, 0);

    // full-width values with output backpressure
    for (int i = 0; i < LANES; i++) begin
      send_beat(~fe_t'(i), fe_t'(i + 1) << 240, 1'b0);
      exp_q[i] = core_f(mk(~fe_t'(i), fe_t'(i + 1) << 240), i);
    end
    collect(LANES, 1);

    // input held valid throughout WAIT/DRAIN must not be consumed
    send_beat(fe_t'(11), fe_t'(22), 1'b0);
    send_beat(fe_t'(33), fe_t'(44), 1'b0);
    send_beat(fe_t'(55), fe_t'(66), 1'b1);
    exp_q[0] = core_f(mk(fe_t'(11), fe_t'(22)), 0);
    exp_q[1] = core_f(mk(fe_t'(33), fe_t'(44)), 1);
    exp_q[2] = core_f(mk(fe_t'(55), fe_t'(66)), 2);
    in_valid = 1'b1;
    in_data  = {fe_t'(99), fe_t'(98)};
    in_last  = 1'b1;
    collect(3, 2);
    chk("t4_in_ready_after", in_ready, 1'b1);
    chk("t4_inState_clear", |perm_inState, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;

    // stale perm_done holds the next batch in LAUNCH
    extra_hold = 5;
    exp_q[0] = {R2, R1, R0};
    send_beat(fe_t'(7), fe_t'(5), 1'b1);
    collect(1, 0);
    send_beat(fe_t'(1), fe_t'(2), 1'b1);
    waited = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (perm_done) begin
        chk("t5_hold_enable", perm_enable, 1'b0);
        waited++;
        @(posedge clk); #1;
      end else begin
        chk("t5_enable_rise", perm_enable, 1'b1);
        seen = 1'b1;
      end
    end
    chk("t5_seen_rise", seen, 1'b1);
    chk("t5_waited", (waited > 0), 1'b1);
    extra_hold = 0;
    exp_q[0] = core_f(mk(fe_t'(1), fe_t'(2)), 0);
    collect(1, 0);

    // reset pulse while waiting for the core
    core_lat = 20;
    send_beat(fe_t'(3), fe_t'(4), 1'b0);
    send_beat(fe_t'(5), fe_t'(6), 1'b1);
    waited = 0;
    while (!perm_enable && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("t6_enable_before", perm_enable, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t6_enable_async", perm_enable, 1'b0);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_inState_zero", |perm_inState, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    core_lat = 2;
    exp_q[0] = {R2, R1, R0};
    send_beat(fe_t'(7), fe_t'(5), 1'b1);
    chk("t6_lane0_in", perm_inState[0], mk(fe_t'(7), fe_t'(5)));
    collect(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rc_batch_driver.md
Name: rc_batch_driver

Overview:
- Initiator and collector for the batched rcPermutation core: the side that drives `inState`/`enable` and consumes `outState`/`done`.
- Accepts rate-sized absorb blocks on a valid/ready stream and packs up to LANES of them into one permutation batch.
- Launches the core, captures the permuted states, and streams them back out in lane order with valid/ready.
- Sits between the hash mode/sponge logic and rcPermutation.

Parameters:
- STATE_SIZE, 3, field elements per state (rate + capacity).
- RATE, 2, elements supplied per input beat; the remaining STATE_SIZE-RATE capacity elements are zero-filled.
- N_BITS, 254, field element width.
- LANES, 13, permutation lanes per batch; must match rcPermutation's lane count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  driver can accept a beat.
- in_data  in  RATE*N_BITS  element j at bits [j*N_BITS +: N_BITS]; passed through unreduced.
- in_last  in  1  closes the current batch with this beat.
- perm_enable  out  1  core enable.
- perm_inState  out  N_BITS x [STATE_SIZE][LANES]  core input states.
- perm_outState  in  N_BITS x [STATE_SIZE][LANES]  core output states.
- perm_done  in  1  core completion, level.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- out_data  out  STATE_SIZE*N_BITS  one permuted lane state; element j at [j*N_BITS +: N_BITS].
- out_last  out  1  marks the final valid lane of the batch.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to FILL; lane count = 0.
  - All outputs 0, and perm_inState all zeros. The one exception is in_ready, which rises in the first cycle after reset deasserts.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready, in_data is written into lane[count] elements 0..RATE-1; capacity elements are 0; count increments.
  - Go to LAUNCH when the accepted beat has in_last=1 or is the LANES-th beat.
  - in_last on the first beat gives a 1-lane batch.
  - in_valid=0 holds FILL indefinitely; there is no timeout.
- Unfilled lanes are zero states [0,0,0]; their results are discarded.
- LAUNCH:
  - in_ready=0.
  - If perm_done=1 (left over from the previous batch), wait here.
  - Otherwise assert perm_enable next cycle and go to WAIT.
- WAIT:
  - perm_enable held 1; perm_inState held stable.
  - On the first cycle perm_done=1: capture all perm_outState into the result buffer, drop perm_enable the next cycle, go to DRAIN with rd index = 0.
- DRAIN:
  - out_valid=1; out_data = buffer[rd]; out_last = (rd == count-1).
  - out_valid/out_data stay stable while out_ready=0.
  - On out_valid&&out_ready: rd increments. After the last lane, clear count and perm_inState to zero and return to FILL; in_ready rises the following cycle.
- Latency:
  - Last input beat to perm_enable: 1 cycle, plus any perm_done wait.
  - perm_done to first out_valid: 1 cycle.
  - Drain throughput: 1 lane/cycle with out_ready=1.
- Input beats are never accepted during LAUNCH, WAIT or DRAIN; there is no double buffering.
- Reset mid-operation:
  - Batch and results are discarded; perm_enable drops asynchronously.
  - A stale perm_done is absorbed by the LAUNCH wait rule.
- Widths: count and rd are $clog2(LANES+1) bits; no arithmetic on data, which is pure storage.

Decomposition:
- rc_pkg holds:
  - localparams N_BITS, STATE_SIZE, LANES, RATE;
  - typedef `fe_t` (logic [N_BITS-1:0]);
  - typedef `lane_state_t` (fe_t [STATE_SIZE]);
  - enum `drv_state_e` {FILL, LAUNCH, WAIT, DRAIN};
  - PRIME_MODULUS and BARRETT_R constants shared with the core.
- One sub-module is natural: rc_lane_buffer, the LANES x STATE_SIZE register file with a write port, bulk capture, indexed read and clear. Both the input and result stores instantiate it.

Test Plan:
- Single beat [7,5] with in_last=1, rcPermutation as DUT-side model:
  - Lane 0 of perm_inState is [7,5,0].
  - One out beat with out_last=1: [12360106593270449844061412657301362366573579256583003766552363058581964117186, 571281065699991603834232145226702411332243584689159097661681181035646779147, 5827211446942541137487801220137246525465448099690109106563675347241842025991].
- Full batch of the 13 standard 2-element vectors, in_last never asserted:
  - Auto-launch after beat 13.
  - 13 out beats in input order; beat 1 equals [9015251630996607203618061446630382221872903244076542510604305929244679444419, …].
  - out_last on beat 13 only.
- Backpressure, 13-lane batch with out_ready toggling 1,0,0,1 repeatedly:
  - Every beat is held stable while stalled.
  - Exactly 13 handshakes; no duplicate or skipped lane.
- in_valid=1 continuously during WAIT/DRAIN:
  - in_ready stays 0 and no beat is consumed.
  - After the final drain handshake, in_ready=1 on the next cycle.
- Core model holds perm_done=1 for 5 cycles after capture:
  - The next batch waits in LAUNCH.
  - perm_enable rises 1 cycle after perm_done falls.
- reset pulled low for 1 cycle during WAIT:
  - perm_enable=0 immediately; out_valid=0 and count=0 afterwards.
  - A fresh [7,5] batch then yields the expected first result.
